// File: rtl/aes_pkg.sv
// Shared Rijndael helpers for the round datapath: byte type, state-width
// legality, per-row ShiftRows offsets and state byte addressing.
// Pure constants/functions; no clocked logic.
package aes_pkg;

    typedef logic [7:0] byte_t;

    // Rijndael defines ShiftRows for 4, 6 and 8 state columns only.
    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Row offset s(r). 256-bit blocks move rows 2 and 3 further to keep
    // diffusion across the wider state.
    function automatic int shift_off(input int nb, input int row);
        if (nb == 8) begin
            case (row)
                2:       return 3;
                3:       return 4;
                default: return row;
            endcase
        end
        return row;
    endfunction

    // Column-major byte layout: byte (row, col) sits at index 4*col + row.
    function automatic int byte_idx(input int row, input int col);
        return 4 * col + row;
    endfunction

endpackage

// File: rtl/shift_rows_comb.sv
// Combinational ShiftRows / InvShiftRows byte permutation of one NB-column state.
// Latency: 0 cycles (pure wiring plus one 2:1 mux per byte).
// Backpressure: none; no handshake, output follows inputs.
// Ports: in_data (32*NB state), inv (1 = inverse), out_data (permuted state).
module shift_rows_comb
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] in_data,
    input  logic             inv,
    output logic [32*NB-1:0] out_data
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int S       = shift_off(NB, r);
            localparam int SRC_FWD = (c + S) % NB;
            localparam int SRC_INV = (c - S + NB) % NB;
            localparam int DST     = byte_idx(r, c);
            localparam int BFWD    = byte_idx(r, SRC_FWD);
            localparam int BINV    = byte_idx(r, SRC_INV);

            assign out_data[8*DST +: 8] = inv ? in_data[8*BINV +: 8]
                                              : in_data[8*BFWD +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows/InvShiftRows stage with a main register and a skid entry.
// Latency: 1 cycle (accepted at edge N, out_valid in cycle N+1); 1 block/cycle.
// Backpressure: valid/ready; in_ready = !skid_v, registered, no path from out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_inv/in_tag;
//        out_valid/out_ready/out_data/out_tag.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int W = 32 * NB;

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shift_rows_pipe: TAG_W must be at least 1");
    end

    logic [W-1:0]     perm_data;
    logic [W-1:0]     main_data, skid_data;
    logic [TAG_W-1:0] main_tag, skid_tag;
    logic             main_v, skid_v;
    logic             accept, xfer;

    // Permute on the way in so both storage entries already hold output bytes.
    shift_rows_comb #(.NB(NB)) u_perm (
        .in_data  (in_data),
        .inv      (in_inv),
        .out_data (perm_data)
    );

    assign accept    = in_valid && in_ready;
    assign xfer      = main_v && out_ready;
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_data;
    assign out_tag   = main_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_data <= '0;
            main_tag  <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else if (!main_v) begin
            // EMPTY: nothing to send, only fill main.
            if (accept) begin
                main_v    <= 1'b1;
                main_data <= perm_data;
                main_tag  <= in_tag;
            end
        end else if (!skid_v) begin
            // MAIN: in_ready is high, so main can be replaced, drained or backed up.
            if (xfer && accept) begin
                main_data <= perm_data;
                main_tag  <= in_tag;
            end else if (xfer) begin
                main_v <= 1'b0;
            end else if (accept) begin
                skid_v    <= 1'b1;
                skid_data <= perm_data;
                skid_tag  <= in_tag;
            end
        end else begin
            // FULL: input is blocked; the skid entry follows main out in order.
            if (xfer) begin
                main_data <= skid_data;
                main_tag  <= skid_tag;
                skid_v    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // NB=4 instance
    logic         in_valid_a, in_ready_a, in_inv_a, out_valid_a, out_ready_a;
    logic [127:0] in_data_a, out_data_a;
    logic [3:0]   in_tag_a, out_tag_a;
    // NB=8 instance
    logic         in_valid_b, in_ready_b, in_inv_b, out_valid_b, out_ready_b;
    logic [255:0] in_data_b, out_data_b;
    logic [3:0]   in_tag_b, out_tag_b;
    // NB=6 instance
    logic         in_valid_c, in_ready_c, in_inv_c, out_valid_c, out_ready_c;
    logic [191:0] in_data_c, out_data_c;
    logic [3:0]   in_tag_c, out_tag_c;

    shift_rows_pipe #(.NB(4), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .in_inv(in_inv_a), .in_tag(in_tag_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .out_tag(out_tag_a));

    shift_rows_pipe #(.NB(8), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .in_inv(in_inv_b), .in_tag(in_tag_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_tag(out_tag_b));

    shift_rows_pipe #(.NB(6), .TAG_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_data(in_data_c), .in_inv(in_inv_c), .in_tag(in_tag_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c),
        .out_data(out_data_c), .out_tag(out_tag_c));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: build the 4xNB byte matrix and rotate each row by its offset.
    function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] d, input logic inv);
        logic [7:0]   st [4][8];
        logic [255:0] res;
        int           s, src;
        res = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[8*(4*c+r) +: 8];
        for (int r = 0; r < 4; r++) begin
            if (nb == 8) s = (r == 2) ? 3 : (r == 3) ? 4 : r;
            else         s = r;
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - s + nb) % nb : (c + s) % nb;
                res[8*(4*c+r) +: 8] = st[r][src];
            end
        end
        return res;
    endfunction

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [3:0]   tag;
        logic [127:0] exp;
    } vec4_t;

    typedef struct {
        logic       inv;
        int         idx;
        logic [7:0] exp;
    } vec8_t;

    typedef struct {
        logic [255:0] d;
        logic [3:0]   t;
    } blk_t;

    blk_t         qc[$];
    logic         held_c_v = 1'b0;
    logic [255:0] held_c;
    int           tx_c = 0;
    int           rx_c = 0;

    // One cycle of traffic on the NB=6 instance, scored against the queue model.
    task automatic cycle_c(input logic v, input logic rdy);
        blk_t e;
        in_valid_c  = v;
        in_data_c   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        in_inv_c    = 1'($urandom_range(0, 1));
        in_tag_c    = 4'($urandom);
        out_ready_c = rdy;
        if (held_c_v)
            check("c_stall_stable", {out_tag_c, out_data_c}, held_c);
        if (out_valid_c && out_ready_c) begin
            check("c_extra_out", 256'(qc.size() == 0), 256'(0));
            if (qc.size() > 0) begin
                e = qc.pop_front();
                check("c_block", {out_tag_c, out_data_c}, {e.t, e.d[191:0]});
            end
            rx_c++;
        end
        held_c_v = out_valid_c && !out_ready_c;
        held_c   = {out_tag_c, out_data_c};
        if (in_valid_c && in_ready_c) begin
            e.d = ref_perm(6, {64'b0, in_data_c}, in_inv_c);
            e.t = in_tag_c;
            qc.push_back(e);
            tx_c++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec4_t        v4[3];
        vec8_t        v8[6];
        logic [127:0] id4;
        logic [255:0] id8;
        blk_t         qa[$];
        blk_t         e;
        logic         held_a_v;
        logic [131:0] held_a;
        int           k, cyc, outs;
        logic         rdy_ok;

        id4 = 128'h0f0e0d0c0b0a09080706050403020100;
        for (int i = 0; i < 32; i++) id8[8*i +: 8] = 8'(i);

        v4[0] = '{id4, 1'b0, 4'h3, 128'h0b06010c07020d08030e09040f0a0500};
        v4[1] = '{id4, 1'b1, 4'h9, 128'h0306090c0f0205080b0e0104070a0d00};
        v4[2] = '{128'h0b06010c07020d08030e09040f0a0500, 1'b1, 4'he, id4};

        v8[0] = '{1'b0, 1, 8'h05};
        v8[1] = '{1'b0, 2, 8'h0e};
        v8[2] = '{1'b0, 3, 8'h13};
        v8[3] = '{1'b1, 1, 8'h1d};
        v8[4] = '{1'b1, 2, 8'h16};
        v8[5] = '{1'b1, 3, 8'h13};

        in_valid_a = 1'b1; in_data_a = id4; in_inv_a = 1'b0; in_tag_a = 4'h5; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0;  in_inv_b = 1'b0; in_tag_b = '0;   out_ready_b = 1'b1;
        in_valid_c = 1'b0; in_data_c = '0;  in_inv_c = 1'b0; in_tag_c = '0;   out_ready_c = 1'b1;

        // Reset state, with a block presented during reset that must be dropped.
        @(posedge clk); @(posedge clk); #1;
        check("rst_out_valid", 256'(out_valid_a), 256'(0));
        check("rst_in_ready",  256'(in_ready_a),  256'(1));
        check("rst_out_data",  256'(out_data_a),  256'(0));
        check("rst_out_tag",   256'(out_tag_a),   256'(0));
        in_valid_a = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_discard", 256'(out_valid_a), 256'(0));

        // NB=4 vector table: one block at a time, output one cycle later.
        for (int i = 0; i < 3; i++) begin
            in_valid_a = 1'b1; in_data_a = v4[i].din; in_inv_a = v4[i].inv; in_tag_a = v4[i].tag;
            @(posedge clk); #1;
            in_valid_a = 1'b0;
            check("nb4_valid", 256'(out_valid_a), 256'(1));
            check("nb4_data",  256'(out_data_a),  256'(v4[i].exp));
            check("nb4_tag",   256'(out_tag_a),   256'(v4[i].tag));
            @(posedge clk); #1;
            check("nb4_drain", 256'(out_valid_a), 256'(0));
        end

        // NB=8 byte table plus a full-state comparison against the model.
        for (int i = 0; i < 6; i++) begin
            in_valid_b = 1'b1; in_data_b = id8; in_inv_b = v8[i].inv; in_tag_b = 4'(i);
            @(posedge clk); #1;
            in_valid_b = 1'b0;
            check("nb8_valid", 256'(out_valid_b), 256'(1));
            check("nb8_byte",  256'(out_data_b[8*v8[i].idx +: 8]), 256'(v8[i].exp));
            check("nb8_full",  out_data_b, ref_perm(8, id8, v8[i].inv));
            @(posedge clk); #1;
        end

        // NB=4 stall: tags 1..8, alternating mode, out_ready low for 3 cycles.
        k = 1; held_a_v = 1'b0; held_a = '0;
        for (cyc = 0; cyc < 60 && (k <= 8 || qa.size() > 0); cyc++) begin
            out_ready_a = (cyc >= 3);
            in_valid_a  = (k <= 8);
            for (int i = 0; i < 16; i++) in_data_a[8*i +: 8] = 8'(k*16 + i*7);
            in_inv_a = (k % 2 == 0);
            in_tag_a = 4'(k);
            if (cyc == 2) check("stall_in_ready_low", 256'(in_ready_a), 256'(0));
            if (cyc == 4) check("stall_in_ready_rise", 256'(in_ready_a), 256'(1));
            if (held_a_v) check("stall_stable", 256'({out_tag_a, out_data_a}), 256'(held_a));
            if (out_valid_a && out_ready_a) begin
                check("stall_extra_out", 256'(qa.size() == 0), 256'(0));
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    check("stall_block", 256'({out_tag_a, out_data_a}), {e.t, e.d[127:0]});
                end
            end
            held_a_v = out_valid_a && !out_ready_a;
            held_a   = {out_tag_a, out_data_a};
            if (in_valid_a && in_ready_a) begin
                e.d = ref_perm(4, {128'b0, in_data_a}, in_inv_a);
                e.t = in_tag_a;
                qa.push_back(e);
                k++;
            end
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        check("stall_all_sent", 256'(k), 256'(9));
        check("stall_all_out",  256'(qa.size()), 256'(0));

        // NB=6 random traffic, 10k blocks.
        for (cyc = 0; cyc < 80000 && rx_c < 10000; cyc++)
            cycle_c(tx_c < 10000 && ($urandom_range(0, 3) != 0), $urandom_range(0, 3) != 0);
        check("rand_received", 256'(rx_c), 256'(10000));
        check("rand_queue_empty", 256'(qc.size()), 256'(0));

        // NB=6 throughput from empty: 100 cycles of valid+ready give 99 outputs.
        outs = rx_c; rdy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!in_ready_c) rdy_ok = 1'b0;
            cycle_c(1'b1, 1'b1);
        end
        check("tput_outputs", 256'(rx_c - outs), 256'(99));
        check("tput_in_ready", 256'(rdy_ok), 256'(1));
        for (int i = 0; i < 3; i++) cycle_c(1'b0, 1'b1);
        check("tput_drained", 256'(qc.size()), 256'(0));
        in_valid_c = 1'b0;

        // Reset while FULL on NB=4, then first block after reset has latency 1.
        out_ready_a = 1'b0; in_valid_a = 1'b1; in_data_a = id4; in_inv_a = 1'b1; in_tag_a = 4'h1;
        @(posedge clk); #1;
        in_tag_a = 4'h2;
        @(posedge clk); #1;
        check("full_before_rst", 256'(in_ready_a), 256'(0));
        rst = 1'b1; in_tag_a = 4'h3;
        @(posedge clk); #1;
        check("rst_full_out_valid", 256'(out_valid_a), 256'(0));
        check("rst_full_in_ready",  256'(in_ready_a),  256'(1));
        rst = 1'b0; out_ready_a = 1'b1; in_inv_a = 1'b0; in_tag_a = 4'h7;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        check("post_rst_valid", 256'(out_valid_a), 256'(1));
        check("post_rst_data",  256'(out_data_a),  256'(128'h0b06010c07020d08030e09040f0a0500));
        check("post_rst_tag",   256'(out_tag_a),   256'(7));
        @(posedge clk); #1;
        check("post_rst_drain", 256'(out_valid_a), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
